// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: the pipeline drives ID/EX state (master), the hazard unit answers (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  ID_Valid;
    logic [REG_ADDR_W-1:0] ID_rs;
    logic [REG_ADDR_W-1:0] ID_rt;
    logic                  ID_UseRs;
    logic                  ID_UseRt;
    logic                  ID_Branch;
    logic                  ID_Taken;
    logic                  EX_RegWrite;
    logic                  EX_MemRead;
    logic [REG_ADDR_W-1:0] EX_Rw;
    logic                  Stall;
    logic                  Bubble;
    logic                  IF_Flush;
    logic [1:0]            StallCause;
    logic [CNT_W-1:0]      StallCnt;

    modport master (
        output ID_Valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_Branch, ID_Taken,
        output EX_RegWrite, EX_MemRead, EX_Rw,
        input  Stall, Bubble, IF_Flush, StallCause, StallCnt
    );

    modport slave (
        input  ID_Valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_Branch, ID_Taken,
        input  EX_RegWrite, EX_MemRead, EX_Rw,
        output Stall, Bubble, IF_Flush, StallCause, StallCnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / branch-operand hazard unit with a LOAD_LAT-deep in-flight load scoreboard.
// Define HAZARD_BRANCH_ID_EN to compile in branch-operand detection for ID-resolved branches.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic                 clk,
    input logic                 reset,
    hazard_scoreboard_if.slave  hz
);

`ifdef HAZARD_BRANCH_ID_EN
    localparam int unsigned SB_DEPTH = LOAD_LAT;
`else
    localparam int unsigned SB_DEPTH = LOAD_LAT - 1;
`endif

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef struct packed {
        logic      v;
        reg_addr_t rw;
    } sb_entry_t;

    logic      id_valid;
    logic      use_rs;
    logic      use_rt;
    reg_addr_t id_rs;
    reg_addr_t id_rt;
    reg_addr_t ex_rw;
    logic      ex_regwrite;
    logic      ex_memread;

    assign id_valid    = hz.ID_Valid;
    assign use_rs      = hz.ID_UseRs;
    assign use_rt      = hz.ID_UseRt;
    assign id_rs       = hz.ID_rs;
    assign id_rt       = hz.ID_rt;
    assign ex_rw       = hz.EX_Rw;
    assign ex_regwrite = hz.EX_RegWrite;
    assign ex_memread  = hz.EX_MemRead;

    // r0 is hardwired zero, so it never carries a dependency
    function automatic logic match_f(input reg_addr_t r);
        return id_valid && (r != '0) &&
               ((use_rs && (id_rs == r)) || (use_rt && (id_rt == r)));
    endfunction

    logic lu_sb;
`ifdef HAZARD_BRANCH_ID_EN
    logic br_sb;
`endif

    generate
        if (SB_DEPTH > 0) begin : g_sb
            localparam int unsigned LU_K = LOAD_LAT - 1;
            localparam logic [SB_DEPTH-1:0] LU_MASK = SB_DEPTH'((1 << LU_K) - 1);

            sb_entry_t [SB_DEPTH-1:0] sb_q;
            sb_entry_t [SB_DEPTH-1:0] sb_d;
            logic      [SB_DEPTH-1:0] sb_hit;

            // Stages past ID always advance, so the shift ignores Stall
            assign sb_d[0].v  = ex_memread & ex_regwrite & (ex_rw != '0);
            assign sb_d[0].rw = ex_rw;

            for (genvar k = 0; k < SB_DEPTH; k++) begin : g_ent
                if (k > 0) begin : g_shift
                    assign sb_d[k] = sb_q[k-1];
                end
                assign sb_hit[k] = sb_q[k].v & match_f(sb_q[k].rw);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sb_q <= '0;
                end else begin
                    sb_q <= sb_d;
                end
            end

            // Entry LOAD_LAT can already forward to EX, so it only matters to an ID-stage compare
            assign lu_sb = |(sb_hit & LU_MASK);
`ifdef HAZARD_BRANCH_ID_EN
            assign br_sb = |sb_hit;
`endif
        end else begin : g_no_sb
            assign lu_sb = 1'b0;
        end
    endgenerate

    logic             load_use_c;
    logic             branch_c;
    logic             stall_c;
    logic [1:0]       cause_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

`ifndef HAZARD_BRANCH_ID_EN
    logic unused_branch;
    assign unused_branch = hz.ID_Branch;
`endif

    // Hazard classification; load-use wins the cause encoding when both are present
    always_comb begin
        load_use_c = ~reset & ((match_f(ex_rw) & ex_memread & ex_regwrite) | lu_sb);
`ifdef HAZARD_BRANCH_ID_EN
        branch_c   = ~reset & hz.ID_Branch & ((match_f(ex_rw) & ex_regwrite) | br_sb);
`else
        branch_c   = 1'b0;
`endif
        stall_c    = load_use_c | branch_c;
        cause_c    = 2'b00;
        if (load_use_c) begin
            cause_c = 2'b01;
        end else if (branch_c) begin
            cause_c = 2'b10;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hz.Stall      = stall_c;
    assign hz.Bubble     = stall_c;
    assign hz.StallCause = cause_c;
    // A stalled branch has not resolved, so its redirect must wait
    assign hz.IF_Flush   = ~reset & hz.ID_Taken & ~stall_c;
    assign hz.StallCnt   = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: three hazard units (LOAD_LAT 1/2/3) checked by a decoupled monitor.
module tb_hazard_scoreboard;

`ifdef HAZARD_BRANCH_ID_EN
    localparam logic BR = 1'b1;
`else
    localparam logic BR = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
        logic       exw;
        logic       exm;
        logic [4:0] exrw;
    } stim_t;

    typedef struct packed {
        logic [1:0]  d;
        logic        stall;
        logic [1:0]  cause;
        logic        flush;
        logic [15:0] cnt;
    } exp_t;

    logic  clk = 1'b0;
    stim_t s1, s2, s3;
    exp_t  exp_q[$];
    string name_q[$];
    int    cnt_m [1:3];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(16)) hz1 ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(4))  hz2 ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(16)) hz3 ();

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .reset(s1.rst), .hz(hz1));
    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(2), .CNT_W(4))  u2 (.clk(clk), .reset(s2.rst), .hz(hz2));
    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .reset(s3.rst), .hz(hz3));

    assign hz1.ID_Valid = s1.valid; assign hz1.ID_rs = s1.rs; assign hz1.ID_rt = s1.rt;
    assign hz1.ID_UseRs = s1.urs;   assign hz1.ID_UseRt = s1.urt;
    assign hz1.ID_Branch = s1.br;   assign hz1.ID_Taken = s1.tk;
    assign hz1.EX_RegWrite = s1.exw; assign hz1.EX_MemRead = s1.exm; assign hz1.EX_Rw = s1.exrw;

    assign hz2.ID_Valid = s2.valid; assign hz2.ID_rs = s2.rs; assign hz2.ID_rt = s2.rt;
    assign hz2.ID_UseRs = s2.urs;   assign hz2.ID_UseRt = s2.urt;
    assign hz2.ID_Branch = s2.br;   assign hz2.ID_Taken = s2.tk;
    assign hz2.EX_RegWrite = s2.exw; assign hz2.EX_MemRead = s2.exm; assign hz2.EX_Rw = s2.exrw;

    assign hz3.ID_Valid = s3.valid; assign hz3.ID_rs = s3.rs; assign hz3.ID_rt = s3.rt;
    assign hz3.ID_UseRs = s3.urs;   assign hz3.ID_UseRt = s3.urt;
    assign hz3.ID_Branch = s3.br;   assign hz3.ID_Taken = s3.tk;
    assign hz3.EX_RegWrite = s3.exw; assign hz3.EX_MemRead = s3.exm; assign hz3.EX_Rw = s3.exrw;

    function automatic stim_t mk(input logic rst, input logic valid, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urs, input logic urt,
                                 input logic br, input logic tk, input logic exw,
                                 input logic exm, input logic [4:0] exrw);
        stim_t s;
        s.rst = rst; s.valid = valid; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
        s.br = br; s.tk = tk; s.exw = exw; s.exm = exm; s.exrw = exrw;
        return s;
    endfunction

    // Drive one cycle into DUT d (others idle) and queue what it must show this cycle
    task automatic step(input int d, input stim_t s, input logic e_st, input logic [1:0] e_c,
                        input logic e_fl, input string nm);
        exp_t e;
        int   cmax;
        cmax = (d == 2) ? 15 : 65535;
        s1 = '0; s2 = '0; s3 = '0;
        case (d)
            1:       s1 = s;
            2:       s2 = s;
            default: s3 = s;
        endcase
        e.d     = 2'(d);
        e.stall = e_st;
        e.cause = e_c;
        e.flush = e_fl;
        e.cnt   = s.rst ? 16'd0 : 16'(cnt_m[d]);
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (s.rst) cnt_m[d] = 0;
        else if (e_st && cnt_m[d] != cmax) cnt_m[d] = cnt_m[d] + 1;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input string f, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, req);
        end
    endtask

    exp_t  mon_e;
    string mon_nm;
    int    a_st, a_bub, a_c, a_fl, a_cnt;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            case (mon_e.d)
                2'd1: begin a_st = int'(hz1.Stall); a_bub = int'(hz1.Bubble); a_c = int'(hz1.StallCause);
                            a_fl = int'(hz1.IF_Flush); a_cnt = int'(hz1.StallCnt); end
                2'd2: begin a_st = int'(hz2.Stall); a_bub = int'(hz2.Bubble); a_c = int'(hz2.StallCause);
                            a_fl = int'(hz2.IF_Flush); a_cnt = int'(hz2.StallCnt); end
                default: begin a_st = int'(hz3.Stall); a_bub = int'(hz3.Bubble); a_c = int'(hz3.StallCause);
                            a_fl = int'(hz3.IF_Flush); a_cnt = int'(hz3.StallCnt); end
            endcase
            chk(mon_nm, "stall",  a_st,  int'(mon_e.stall));
            chk(mon_nm, "bubble", a_bub, int'(mon_e.stall));
            chk(mon_nm, "cause",  a_c,   int'(mon_e.cause));
            chk(mon_nm, "flush",  a_fl,  int'(mon_e.flush));
            chk(mon_nm, "cnt",    a_cnt, int'(mon_e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        s1 = '0; s2 = '0; s3 = '0;
        s1.rst = 1'b1; s2.rst = 1'b1; s3.rst = 1'b1;
        cnt_m[1] = 0; cnt_m[2] = 0; cnt_m[3] = 0;
        repeat (2) @(posedge clk);
        #1;

        // LOAD_LAT=1: reset masking, basic load-use, r0 and unused-operand cases, flush
        step(1, mk(H,H,5'd8,5'd0,H,L,L,H,H,H,5'd8), L, 2'b00, L, "rst_force");
        step(1, mk(L,H,5'd8,5'd0,H,L,L,L,H,H,5'd8), H, 2'b01, L, "ll1_lu");
        step(1, mk(L,H,5'd8,5'd0,H,L,L,L,L,L,5'd0), L, 2'b00, L, "ll1_after");
        step(1, mk(L,H,5'd0,5'd0,H,L,L,L,H,H,5'd0), L, 2'b00, L, "r0_load");
        step(1, mk(L,H,5'd9,5'd8,H,L,L,L,H,H,5'd8), L, 2'b00, L, "rt_unused");
        step(1, mk(L,H,5'd9,5'd8,H,H,L,L,H,H,5'd8), H, 2'b01, L, "rt_used");
        step(1, mk(L,L,5'd8,5'd0,H,L,L,L,H,H,5'd8), L, 2'b00, L, "id_invalid");
        step(1, mk(L,H,5'd8,5'd0,H,L,L,L,L,L,5'd0), L, 2'b00, L, "ll1_ex_only");
        step(1, mk(L,H,5'd1,5'd2,H,H,L,H,L,L,5'd0), L, 2'b00, H, "flush_nohaz");
        step(1, mk(L,H,5'd3,5'd0,H,L,L,L,H,L,5'd3), L, 2'b00, L, "alu_no_lu");

        // LOAD_LAT=3: back-to-back consumer, then one independent instruction in between
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,H,H,5'd5), H, 2'b01, L, "ll3_c0");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,L,L,5'd0), H, 2'b01, L, "ll3_c1");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,L,L,5'd0), H, 2'b01, L, "ll3_c2");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,L,L,5'd0), L, 2'b00, L, "ll3_c3");
        step(3, mk(L,H,5'd6,5'd0,H,L,L,L,H,H,5'd5), L, 2'b00, L, "ll3_indep");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,H,L,5'd7), H, 2'b01, L, "ll3_gap_c1");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,L,L,5'd0), H, 2'b01, L, "ll3_gap_c2");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,L,L,5'd0), L, 2'b00, L, "ll3_gap_done");

        // LOAD_LAT=3: reset while stalled with a full scoreboard
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,H,H,5'd5),  H, 2'b01, L, "rs_c0");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,H,H,5'd6),  H, 2'b01, L, "rs_c1");
        step(3, mk(L,H,5'd5,5'd0,H,L,L,L,H,H,5'd7),  H, 2'b01, L, "rs_c2");
        step(3, mk(H,H,5'd7,5'd6,H,H,L,H,H,H,5'd10), L, 2'b00, L, "rs_assert");
        step(3, mk(L,H,5'd7,5'd10,H,H,L,L,L,L,5'd0), L, 2'b00, L, "rs_after");

        // LOAD_LAT=2: branch operands behind ALU and load producers, taken branch flush
        step(2, mk(L,H,5'd3,5'd4,H,H,H,H,H,L,5'd3), BR, BR ? 2'b10 : 2'b00, ~BR, "br_alu");
        step(2, mk(L,H,5'd3,5'd4,H,H,H,H,L,L,5'd0), L,  2'b00,              H,   "br_alu_done");
        step(2, mk(L,H,5'd3,5'd4,H,H,H,H,H,H,5'd3), H,  2'b01,              L,   "br_ld_c0");
        step(2, mk(L,H,5'd3,5'd4,H,H,H,H,L,L,5'd0), H,  2'b01,              L,   "br_ld_c1");
        step(2, mk(L,H,5'd3,5'd4,H,H,H,H,L,L,5'd0), BR, BR ? 2'b10 : 2'b00, ~BR, "br_ld_c2");
        step(2, mk(L,H,5'd3,5'd4,H,H,H,H,L,L,5'd0), L,  2'b00,              H,   "br_ld_done");
        step(2, mk(L,H,5'd3,5'd0,H,L,L,L,H,L,5'd3), L,  2'b00,              L,   "nobr_alu");

        // CNT_W=4 saturation
        for (int i = 0; i < 20; i++)
            step(2, mk(L,H,5'd9,5'd0,H,L,L,L,H,H,5'd9), H, 2'b01, L, "sat");
        step(2, mk(L,L,5'd0,5'd0,L,L,L,L,L,L,5'd0), L, 2'b00, L, "sat_hold");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection unit for the pipelined MIPS core, sitting beside the ID stage. It tracks in-flight load destinations through a configurable number of memory stages, issues the PC/IF-ID hold and ID/EX bubble, and generates the IF flush for taken branches. It counts stall cycles for performance analysis. It supersedes the single-stage load-use detector.

## Interface
- REG_ADDR_W, 5: register-address width.
- LOAD_LAT, 1: memory stages (MEM1..MEMn) before load data can be forwarded; legal 1..4.
- CNT_W, 16: width of the stall counter.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- ID_Valid  in  1  ID holds a real instruction.
- ID_rs, ID_rt  in  REG_ADDR_W  ID source registers.
- ID_UseRs, ID_UseRt  in  1  instruction actually reads rs/rt.
- ID_Branch  in  1  branch/jr resolved in ID, compares rs/rt in ID.
- ID_Taken  in  1  ID branch/jump redirects PC this cycle.
- EX_RegWrite, EX_MemRead  in  1  ID/EX control of the instruction in EX.
- EX_Rw  in  REG_ADDR_W  destination of the instruction in EX.
- Stall  out  1  hold PC and IF/ID.
- Bubble  out  1  zero ID/EX control; always equals Stall.
- IF_Flush  out  1  clear IF/ID, because a wrong-path fetch occurred.
- StallCause  out  2  00 none, 01 load-use, 10 branch-operand.
- StallCnt  out  CNT_W  saturating count of stall cycles.

## Operation
- A scoreboard holds LOAD_LAT entries {v, rw}. Entry k is the load currently in MEMk.
- Every cycle, the scoreboard shifts by one entry: entry1 ← {EX_MemRead & EX_RegWrite & (EX_Rw≠0), EX_Rw}, and entry k+1 ← entry k. The oldest entry is dropped. The shift happens regardless of Stall, because the stages past ID always advance.
- match(r) = ID_Valid & (r≠0) & ((ID_UseRs & ID_rs==r) | (ID_UseRt & ID_rt==r)). Register 0 never causes a hazard.
- Load-use hazard: match(EX_Rw) & EX_MemRead & EX_RegWrite, or match(entry k.rw) & entry k.v for any k ≤ LOAD_LAT−1.
- Branch-operand hazard (macro only): ID_Branch & any of the following:
  - match(EX_Rw) & EX_RegWrite;
  - match(entry k.rw) & entry k.v for any k ≤ LOAD_LAT.
- Stall = load-use | branch-operand. When both hazards are present, StallCause reports load-use (01).
- IF_Flush = ID_Taken & ~Stall. A stalled branch has not resolved yet.
- StallCnt increments by 1 on each edge where Stall=1, and saturates at 2^CNT_W−1.
- reset clears all scoreboard entries and StallCnt. While reset=1, Stall, Bubble and IF_Flush are forced to 0 and StallCause is 00.

## Timing
- Stall, Bubble, StallCause and IF_Flush are combinational from the current inputs and scoreboard state, and are valid in the same cycle.
- The scoreboard and StallCnt update on the rising edge.
- Reset values: every output is 0, and every entry has v=0.
- Load-use penalty: LOAD_LAT cycles for a consumer directly behind the load; one cycle less for each independent instruction placed between them.
- Branch penalties (macro on):
  - ALU producer directly ahead of the branch: 1 cycle.
  - Load producer directly ahead of the branch: LOAD_LAT+1 cycles.
- The bubble inserted during a stall carries EX_RegWrite=0, so it enters the scoreboard as v=0.
- When reset is asserted mid-stall, the scoreboard is clear on the next cycle and Stall=0.
- With LOAD_LAT=1, only EX is checked for load-use.

## Configuration
- HAZARD_BRANCH_ID_EN defined: branch-operand detection is compiled in and StallCause can be 10. This is required when branches compare in ID.
- HAZARD_BRANCH_ID_EN undefined:
  - ID_Branch is ignored and only load-use stalls are raised.
  - StallCause never takes the value 10.
  - The scoreboard depth reduces to LOAD_LAT−1; no scoreboard exists when LOAD_LAT=1.

## Test plan
- LOAD_LAT=1, EX has lw to r8, ID has add reading rs=r8 → Stall=1 and StallCause=01 for 1 cycle. The next cycle Stall=0 and StallCnt=1.
- LOAD_LAT=3, lw to r5 followed directly by a consumer of r5 → Stall high for 3 consecutive cycles, then low; StallCnt=3.
- Load to r0 in EX, ID reads r0 → Stall=0. Also, ID_UseRt=0 with ID_rt matching the load destination → Stall=0.
- Macro on, LOAD_LAT=2, EX has addu to r3 (no load) and ID has beq on r3 → 1-cycle stall with cause 10. With lw to r3 instead → 3 stall cycles with cause 01, 01, 10.
- ID_Taken=1 with no hazard → IF_Flush=1. ID_Taken=1 during a stall → IF_Flush=0 until the stall clears, then 1.
- Reset asserted while the scoreboard is full during a stall → outputs are 0 that cycle; the next cycle has no stall and StallCnt=0. Saturation check: with CNT_W=4, after 20 stall cycles StallCnt=15.
